// File: rtl/fa_response_checker.sv
// fa_response_checker
// Receiving end of a single-bit full adder's stimulus/response interface.
// Each accepted sample {input_1,input_2,carry_in} is checked against the
// DUT's {sum,carry_out}. The block counts mismatches (saturating), records
// the first failing vector and tracks coverage of all 8 input combinations.
// A run begins with a start pulse. It ends after VEC_COUNT accepted samples.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             single-cycle pulse, begins a run (ignored in RUN)
//   sample_valid      input/response bits valid this cycle
//   input_1, input_2, carry_in   applied adder operands
//   sum, carry_out    adder responses under check
//   busy / done       registered state decodes (RUN / DONE)
//   pass              no errors and full coverage, valid while done
//   err_count         saturating mismatch count
//   first_err_valid, first_err_vec   first mismatching vector of the run
//   coverage          bit k set once vector k has been sampled
//   sample_count      samples accepted this run
module fa_response_checker #(
  parameter int VEC_COUNT = 8,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             input_1,
  input  logic             input_2,
  input  logic             carry_in,
  input  logic             sum,
  input  logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec,
  output logic [7:0]       coverage,
  output logic [7:0]       sample_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic             r_busy, r_done, r_pass, r_fev;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_fvec;
  logic [7:0]       r_cov, r_cnt;

  logic [2:0]       w_vec;
  logic             w_exp_sum, w_exp_cout, w_mis;
  logic             w_accept, w_last, w_clear;
  logic [ERR_W-1:0] w_err_next;
  logic [7:0]       w_cov_next;

  assign w_vec      = {input_1, input_2, carry_in};
  assign w_exp_sum  = input_1 ^ input_2 ^ carry_in;
  assign w_exp_cout = (input_1 & input_2) | (input_1 & carry_in) | (input_2 & carry_in);
  assign w_mis      = (sum != w_exp_sum) || (carry_out != w_exp_cout);

  assign w_accept = (r_state == RUN) && sample_valid;
  assign w_last   = w_accept && (r_cnt == 8'(VEC_COUNT - 1));
  // Start only counts outside RUN; a coincident sample is dropped.
  assign w_clear  = (r_state != RUN) && start;

  // Post-sample results, so pass includes the final sample of the run.
  assign w_err_next = (w_accept && w_mis && (r_err != {ERR_W{1'b1}}))
                      ? r_err + ERR_W'(1) : r_err;
  assign w_cov_next = w_accept ? (r_cov | (8'b1 << w_vec)) : r_cov;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (start)  w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_fvec <= '0;
      r_cov  <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_clear) begin
        r_pass <= 1'b0;
        r_err  <= '0;
        r_fev  <= 1'b0;
        r_fvec <= '0;
        r_cov  <= '0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 8'd1;
        r_cov <= w_cov_next;
        r_err <= w_err_next;
        if (w_mis && !r_fev) begin
          r_fev  <= 1'b1;
          r_fvec <= w_vec;
        end
        if (w_last)
          r_pass <= (w_err_next == '0) && (w_cov_next == 8'hFF);
      end
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_valid = r_fev;
  assign first_err_vec   = r_fvec;
  assign coverage        = r_cov;
  assign sample_count    = r_cnt;

endmodule

// File: tb/tb_fa_response_checker.sv
module tb_fa_response_checker;
  localparam int VC = 8;

  logic clk = 0, rst = 1, start = 0, sv = 0;
  logic a = 0, b = 0, ci = 0, s = 0, co = 0;

  logic       busy, done, pass, fev;
  logic [7:0] err, cov, scnt;
  logic [2:0] fvec;
  logic       busy2, done2, pass2, fev2;
  logic [1:0] err2;
  logic [7:0] cov2, scnt2;
  logic [2:0] fvec2;

  fa_response_checker #(.VEC_COUNT(VC), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sv),
    .input_1(a), .input_2(b), .carry_in(ci), .sum(s), .carry_out(co),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_err_valid(fev), .first_err_vec(fvec), .coverage(cov),
    .sample_count(scnt));

  fa_response_checker #(.VEC_COUNT(VC), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sv),
    .input_1(a), .input_2(b), .carry_in(ci), .sum(s), .carry_out(co),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fvec2), .coverage(cov2),
    .sample_count(scnt2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] err8;
    logic [1:0] err2;
    logic       fev;
    logic [2:0] fvec;
    logic [7:0] cov;
    logic       pass;
  } exp_t;
  exp_t q[$];

  logic [2:0] v_vec[VC];
  bit         v_bs[VC], v_bc[VC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response from arithmetic: sum is the parity of the total, carry is total/2.
  task automatic drive(input bit st, input bit v, input logic [2:0] vec,
                       input bit bs, input bit bc);
    int tot;
    @(negedge clk);
    tot   = int'(vec[2]) + int'(vec[1]) + int'(vec[0]);
    start = st;
    sv    = v;
    {a, b, ci} = vec;
    s  = 1'((tot % 2)) ^ bs;
    co = 1'((tot / 2)) ^ bc;
  endtask

  // Monitor: on each rising done, pop the expected run result and compare.
  logic done_q = 0;
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("busy_in_done", busy, 0);
        chk("err_count", err, e.err8);
        chk("err_count_w2", err2, e.err2);
        chk("first_err_valid", fev, e.fev);
        chk("first_err_vec", fvec, e.fvec);
        chk("coverage", cov, e.cov);
        chk("sample_count", scnt, VC);
        chk("pass", pass, e.pass);
        chk("pass_w2", pass2, e.pass);
        chk("done_w2", done2, 1);
      end
    end
    done_q <= done;
  end

  task automatic do_run(input int n, input bit gaps, input bit midst);
    exp_t       e;
    int         nerr = 0, t = 0;
    logic [7:0] mcov = 0;
    bit         mfev = 0;
    logic [2:0] mfv  = 0;
    // Start, possibly with a coincident sample that must be dropped.
    drive(1, 1'($urandom_range(1)), 3'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    chk("start_err_clr", err, 0);
    chk("start_cov_clr", cov, 0);
    chk("start_cnt_clr", scnt, 0);
    chk("start_fev_clr", fev, 0);
    start = 0;
    sv    = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps)
        repeat ($urandom_range(2))
          drive(midst & 1'($urandom), 0, 3'($urandom), 1'($urandom), 1'($urandom));
      if (v_bs[i] || v_bc[i]) begin
        if (!mfev) begin mfev = 1; mfv = v_vec[i]; end
        nerr++;
      end
      mcov = mcov | (8'b1 << v_vec[i]);
      drive(midst & 1'($urandom), 1, v_vec[i], v_bs[i], v_bc[i]);
      if (i == VC - 1) begin
        e.cyc  = cyc + 1;
        e.err8 = (nerr > 255) ? 8'd255 : 8'(nerr);
        e.err2 = (nerr > 3) ? 2'd3 : 2'(nerr);
        e.fev  = mfev;
        e.fvec = mfv;
        e.cov  = mcov;
        e.pass = (nerr == 0) && (mcov == 8'hFF);
        q.push_back(e);
      end
    end
    @(negedge clk);
    sv    = 0;
    start = 0;
    if (n == VC) begin
      while (!done && t < 10) begin @(negedge clk); t++; end
      chk("done_timeout", done, 1);
      // Samples in DONE must not disturb the held results.
      repeat (3) drive(0, 1, 3'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      sv = 0;
      chk("hold_cnt", scnt, VC);
      chk("hold_err", err, e.err8);
      chk("hold_cov", cov, e.cov);
      chk("hold_done", done, 1);
    end
  endtask

  task automatic set_sweep();
    for (int i = 0; i < VC; i++) begin
      v_vec[i] = 3'(i); v_bs[i] = 0; v_bc[i] = 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_fev", fev, 0);
    chk("rst_fvec", fvec, 0);
    chk("rst_cov", cov, 0);
    chk("rst_cnt", scnt, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Correct sweep.
    set_sweep();
    do_run(VC, 0, 0);

    // Faults: sum wrong on vectors 1 and 7.
    set_sweep();
    v_bs[1] = 1; v_bs[7] = 1;
    do_run(VC, 0, 0);

    // Coverage hole: 5 twice, 6 never.
    set_sweep();
    v_vec[6] = 3'd5;
    do_run(VC, 0, 0);

    // Gapped valid plus start pulses mid-run, shuffled order.
    set_sweep();
    for (int i = VC - 1; i > 0; i--) begin
      int j;
      logic [2:0] tmp;
      j = $urandom_range(i);
      tmp = v_vec[i]; v_vec[i] = v_vec[j]; v_vec[j] = tmp;
    end
    do_run(VC, 1, 1);

    // Reset mid-run after 4 samples.
    set_sweep();
    do_run(4, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cov", cov, 0);
    chk("mid_rst_cnt", scnt, 0);
    @(negedge clk);
    rst = 0;
    do_run(VC, 0, 0);

    // All responses wrong: 2-bit counter saturates at 3.
    set_sweep();
    for (int i = 0; i < VC; i++) begin
      v_bs[i] = 1'($urandom);
      v_bc[i] = ~v_bs[i] | 1'($urandom);
    end
    do_run(VC, 0, 0);
    // Restart from DONE clears results (checked inside do_run).
    set_sweep();
    do_run(VC, 0, 0);

    // Random runs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < VC; i++) begin
        v_vec[i] = 3'($urandom);
        v_bs[i]  = ($urandom_range(3) == 0);
        v_bc[i]  = ($urandom_range(3) == 0);
      end
      do_run(VC, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
